// File: rtl/masked_sbox_driver.sv
// Issuing side of the Synch interface for a first-order HPC2 4-bit Skinny S-box.
// Launches one shared nibble at a time, feeds LFSR randomness, waits for Synch, returns the shares.
module masked_sbox_driver #(
    parameter int          LATENCY     = 10,
    parameter int          FRESH_WIDTH = 13,
    parameter int          TIMEOUT     = 32,
    parameter logic [31:0] SEED        = 32'h1ACE_B00C
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [3:0]             in_s0,
    input  logic [3:0]             in_s1,
    input  logic                   seed_load,
    input  logic [31:0]            seed,
    output logic                   sbox_rst,
    output logic [3:0]             SI_s0,
    output logic [3:0]             SI_s1,
    output logic [FRESH_WIDTH-1:0] Fresh,
    input  logic [3:0]             SO_s0,
    input  logic [3:0]             SO_s1,
    input  logic                   Synch,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [3:0]             out_s0,
    output logic [3:0]             out_s1,
    output logic                   err
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_START   = 3'd1;
    localparam logic [2:0] S_WAIT    = 3'd2;
    localparam logic [2:0] S_CAPTURE = 3'd3;
    localparam logic [2:0] S_OUT     = 3'd4;

    // Right-shifting Galois form of x^32+x^22+x^2+x+1.
    localparam logic [31:0] TAPS = 32'h8020_0003;
    localparam int CW = $clog2(TIMEOUT);

    if (TIMEOUT <= LATENCY + 1) begin : g_bad_timeout
        $error("TIMEOUT must exceed LATENCY+1");
    end

    logic [2:0]    state;
    logic [CW-1:0] wait_cnt;
    logic [31:0]   lfsr;
    logic [31:0]   lfsr_step;

    assign in_ready  = !rst && (state == S_IDLE);
    assign sbox_rst  = rst || (state == S_START);
    assign out_valid = (state == S_OUT);
    assign Fresh     = lfsr[FRESH_WIDTH-1:0];
    assign lfsr_step = lfsr[0] ? ((lfsr >> 1) ^ TAPS) : (lfsr >> 1);

    // A zero seed would lock the LFSR, so it falls back to SEED.
    always_ff @(posedge clk) begin
        if (rst)
            lfsr <= SEED;
        else if (seed_load && state == S_IDLE)
            lfsr <= (seed == 32'd0) ? SEED : seed;
        else
            lfsr <= lfsr_step;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
            SI_s0    <= 4'd0;
            SI_s1    <= 4'd0;
            out_s0   <= 4'd0;
            out_s1   <= 4'd0;
            err      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (in_valid) begin
                    SI_s0 <= in_s0;
                    SI_s1 <= in_s1;
                    state <= S_START;
                end
                S_START: begin
                    wait_cnt <= '0;
                    state    <= S_WAIT;
                end
                // Synch in the last allowed cycle still wins over the timeout.
                S_WAIT: begin
                    if (Synch)
                        state <= S_CAPTURE;
                    else if (wait_cnt == CW'(TIMEOUT - 1)) begin
                        err   <= 1'b1;
                        state <= S_IDLE;
                    end else
                        wait_cnt <= wait_cnt + CW'(1);
                end
                S_CAPTURE: begin
                    out_s0 <= SO_s0;
                    out_s1 <= SO_s1;
                    state  <= S_OUT;
                end
                S_OUT: if (out_ready) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_masked_sbox_driver.sv
// Bench for masked_sbox_driver: behavioural S-box/Synch responder plus a polynomial LFSR model.
module tb_masked_sbox_driver;
    localparam logic [31:0] SEED = 32'h1ACE_B00C;
    localparam int FW = 13;

    logic clk = 0, rst = 1, in_valid = 0, seed_load = 0, out_ready = 0;
    logic [3:0] in_s0 = 0, in_s1 = 0, SO_s0 = 0, SO_s1 = 0;
    logic [31:0] seed = 0;
    logic in_ready, sbox_rst, out_valid, err, Synch;
    logic [3:0] SI_s0, SI_s1, out_s0, out_s1;
    logic [FW-1:0] Fresh;

    int n_cmp = 0, n_err = 0, cyc = 0;
    logic [3:0] SBOX [16] = '{4'hc, 4'h6, 4'h9, 4'h0, 4'h1, 4'ha, 4'h2, 4'hb,
                              4'h3, 4'h8, 4'h5, 4'hd, 4'h4, 4'he, 4'h7, 4'hf};

    masked_sbox_driver dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_s0(in_s0), .in_s1(in_s1), .seed_load(seed_load), .seed(seed),
        .sbox_rst(sbox_rst), .SI_s0(SI_s0), .SI_s1(SI_s1), .Fresh(Fresh),
        .SO_s0(SO_s0), .SO_s1(SO_s1), .Synch(Synch), .out_valid(out_valid),
        .out_ready(out_ready), .out_s0(out_s0), .out_s1(out_s1), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // LFSR state as a GF(2) polynomial, stepped by multiplying with x^-1 mod p(x).
    logic [31:0] m_lfsr;
    function automatic logic [31:0] poly_step(input logic [31:0] s);
        logic [32:0] p = 33'h1_0040_0007;
        logic [32:0] t = {1'b0, s};
        if (s[0]) t = t ^ p;
        return t[32:1];
    endfunction
    always @(posedge clk) begin
        if (rst) m_lfsr <= SEED;
        else if (seed_load) m_lfsr <= (seed == 0) ? SEED : seed;
        else m_lfsr <= poly_step(m_lfsr);
    end

    // S-box responder: Synch 11 cycles after the sbox_rst cycle, result shares one cycle later.
    logic synch_en = 1, synch_m = 0, synch_x = 0, act = 0;
    int k = 0;
    logic [3:0] m_o0 = 0, m_o1 = 0;
    assign Synch = synch_m | synch_x;
    always @(negedge clk) begin
        if (rst) begin
            act = 0; synch_m = 0;
        end else if (sbox_rst) begin
            act = 1; k = 0; synch_m = 0;
        end else if (act) begin
            k++;
            if (k == 11 && synch_en) synch_m = 1;
            else if (k == 12) begin
                synch_m = 0;
                if (synch_en) begin
                    m_o0 = 4'($urandom);
                    m_o1 = m_o0 ^ SBOX[SI_s0 ^ SI_s1];
                    SO_s0 = m_o0; SO_s1 = m_o1;
                end
            end else if (k == 13) begin
                SO_s0 = 4'($urandom); SO_s1 = 4'($urandom); act = 0;
            end
        end
    end

    task automatic do_txn(input logic [3:0] s0, input logic [3:0] s1, input int hold,
                          input bit spur, output int a);
        logic [3:0] x = s0 ^ s1;
        for (int i = 0; i < 100 && in_ready !== 1'b1; i++) @(negedge clk);
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL txn_ready_wait got=%b want=1", in_ready); end
        a = cyc;
        in_valid = 1; in_s0 = s0; in_s1 = s1;
        @(negedge clk);
        in_valid = 0; seed_load = 0; in_s0 = 4'($urandom); in_s1 = 4'($urandom);
        n_cmp++; if ({sbox_rst, in_ready, SI_s0, SI_s1} !== {2'b10, s0, s1}) begin
            n_err++; $display("FAIL txn_start got=%b/%b/%h%h want=1/0/%h%h", sbox_rst, in_ready, SI_s0, SI_s1, s0, s1); end
        n_cmp++; if (Fresh !== m_lfsr[FW-1:0]) begin n_err++; $display("FAIL txn_fresh_start got=%h want=%h", Fresh, m_lfsr[FW-1:0]); end
        for (int c = 2; c <= 13; c++) begin
            @(negedge clk);
            n_cmp++; if ({sbox_rst, in_ready, out_valid, SI_s0, SI_s1} !== {3'b000, s0, s1}) begin
                n_err++; $display("FAIL txn_wait cyc+%0d got=%b%b%b/%h%h want=000/%h%h", c, sbox_rst, in_ready, out_valid, SI_s0, SI_s1, s0, s1); end
            n_cmp++; if (Fresh !== m_lfsr[FW-1:0]) begin n_err++; $display("FAIL txn_fresh cyc+%0d got=%h want=%h", c, Fresh, m_lfsr[FW-1:0]); end
        end
        @(negedge clk);
        n_cmp++; if ({out_valid, out_s0, out_s1} !== {1'b1, m_o0, m_o1}) begin
            n_err++; $display("FAIL txn_out got=%b/%h%h want=1/%h%h", out_valid, out_s0, out_s1, m_o0, m_o1); end
        n_cmp++; if ((out_s0 ^ out_s1) !== SBOX[x]) begin n_err++; $display("FAIL txn_sbox x=%h got=%h want=%h", x, out_s0 ^ out_s1, SBOX[x]); end
        out_ready = (hold == 0);
        for (int h = 1; h <= hold; h++) begin
            @(negedge clk);
            synch_x = spur && (h == 1);
            n_cmp++; if ({out_valid, in_ready, out_s0, out_s1} !== {2'b10, m_o0, m_o1}) begin
                n_err++; $display("FAIL txn_hold h=%0d got=%b%b/%h%h want=10/%h%h", h, out_valid, in_ready, out_s0, out_s1, m_o0, m_o1); end
            out_ready = (h == hold);
        end
        @(negedge clk);
        synch_x = 0; out_ready = 0;
        n_cmp++; if ({out_valid, in_ready} !== 2'b01) begin n_err++; $display("FAIL txn_done got=%b%b want=01", out_valid, in_ready); end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++; if ({in_ready, sbox_rst, out_valid, err, SI_s0, SI_s1, out_s0, out_s1} !== {4'b0100, 16'h0}) begin
            n_err++; $display("FAIL reset_vals got=%b%b%b%b/%h%h%h%h want=0100/0000", in_ready, sbox_rst, out_valid, err, SI_s0, SI_s1, out_s0, out_s1); end
        n_cmp++; if (Fresh !== 13'(SEED)) begin n_err++; $display("FAIL reset_fresh got=%h want=%h", Fresh, 13'(SEED)); end
        rst = 0;
        @(negedge clk);
        n_cmp++; if ({in_ready, sbox_rst} !== 2'b10) begin n_err++; $display("FAIL reset_release got=%b%b want=10", in_ready, sbox_rst); end
        n_cmp++; if (Fresh !== m_lfsr[FW-1:0]) begin n_err++; $display("FAIL reset_fresh_step got=%h want=%h", Fresh, m_lfsr[FW-1:0]); end
    endtask

    task automatic test_basic();
        int a;
        do_txn(4'h5, 4'h5, 0, 0, a);
    endtask

    task automatic test_sweep();
        int a, last;
        logic [3:0] s0;
        for (int x = 0; x < 16; x++) begin
            s0 = 4'($urandom);
            do_txn(s0, s0 ^ 4'(x), 0, 0, a);
            if (x > 0) begin
                n_cmp++; if (a - last !== 15) begin n_err++; $display("FAIL sweep_spacing got=%0d want=15", a - last); end
            end
            last = a;
        end
    endtask

    task automatic test_back_pressure();
        int a;
        do_txn(4'($urandom), 4'($urandom), 20, 1, a);
    endtask

    task automatic test_timeout();
        int a;
        synch_en = 0;
        a = cyc; in_valid = 1; in_s0 = 4'h9; in_s1 = 4'h3;
        @(negedge clk); in_valid = 0;
        n_cmp++; if (sbox_rst !== 1'b1) begin n_err++; $display("FAIL to_start got=%b want=1", sbox_rst); end
        for (int c = 2; c <= 33; c++) begin
            @(negedge clk);
            n_cmp++; if ({err, in_ready, out_valid} !== 3'b000) begin n_err++; $display("FAIL to_wait cyc+%0d got=%b%b%b want=000", c, err, in_ready, out_valid); end
        end
        @(negedge clk);
        n_cmp++; if ({err, in_ready, out_valid} !== 3'b110) begin n_err++; $display("FAIL to_abort got=%b%b%b want=110", err, in_ready, out_valid); end
        synch_en = 1;
        do_txn(4'h1, 4'h7, 0, 0, a);
        n_cmp++; if (err !== 1'b1) begin n_err++; $display("FAIL to_sticky got=%b want=1", err); end
    endtask

    task automatic test_reset_mid();
        int a;
        in_valid = 1; in_s0 = 4'h3; in_s1 = 4'h4;
        @(negedge clk); in_valid = 0;
        for (int c = 2; c <= 6; c++) @(negedge clk);
        rst = 1;
        @(negedge clk);
        n_cmp++; if ({sbox_rst, in_ready, out_valid, err, SI_s0, SI_s1} !== {4'b1000, 8'h00}) begin
            n_err++; $display("FAIL rmid_vals got=%b%b%b%b/%h%h want=1000/00", sbox_rst, in_ready, out_valid, err, SI_s0, SI_s1); end
        n_cmp++; if (Fresh !== 13'(SEED)) begin n_err++; $display("FAIL rmid_fresh got=%h want=%h", Fresh, 13'(SEED)); end
        rst = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            n_cmp++; if ({in_ready, out_valid, sbox_rst} !== 3'b100) begin n_err++; $display("FAIL rmid_idle c=%0d got=%b%b%b want=100", c, in_ready, out_valid, sbox_rst); end
        end
        do_txn(4'hA, 4'h8, 0, 0, a);
    endtask

    task automatic test_seed();
        int a;
        seed_load = 1; seed = 32'd0;
        @(negedge clk); seed_load = 0;
        n_cmp++; if (Fresh !== 13'(SEED)) begin n_err++; $display("FAIL seed_zero got=%h want=%h", Fresh, 13'(SEED)); end
        seed_load = 1; seed = 32'd1;
        @(negedge clk); seed_load = 0;
        n_cmp++; if (Fresh !== 13'd1) begin n_err++; $display("FAIL seed_one got=%h want=0001", Fresh); end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            n_cmp++; if (Fresh !== m_lfsr[FW-1:0]) begin n_err++; $display("FAIL seed_seq c=%0d got=%h want=%h", c, Fresh, m_lfsr[FW-1:0]); end
        end
        seed_load = 1; seed = $urandom | 32'h0001_0000;
        do_txn(4'($urandom), 4'($urandom), 0, 0, a);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_sweep();
        test_back_pressure();
        test_timeout();
        test_reset_mid();
        test_seed();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
